// File: rtl/bk_clk_pkg.sv
// Shared constants and types for the clock-enable / reset sequencer.
package bk_clk_pkg;

    // CPU speed select encoding
    localparam logic [1:0] SPD_3M = 2'd0;
    localparam logic [1:0] SPD_4M = 2'd1;
    localparam logic [1:0] SPD_6M = 2'd2;

    // CPU divisors (clk_sys cycles per CPU period)
    localparam int unsigned DIV_W  = 6;
    localparam logic [DIV_W-1:0] DIV_3M = 6'd32;
    localparam logic [DIV_W-1:0] DIV_4M = 6'd24;
    localparam logic [DIV_W-1:0] DIV_6M = 6'd16;

    // CPU phase counter width
    localparam int unsigned CPU_CNT_W = 5;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_COUNT,
        ST_RUN
    } state_e;

    // Map speed code to divisor; the unused code 3 aliases 4 MHz.
    function automatic logic [DIV_W-1:0] speed_div(input logic [1:0] spd);
        logic [DIV_W-1:0] d;
        case (spd)
            SPD_3M:  d = DIV_3M;
            SPD_6M:  d = DIV_6M;
            default: d = DIV_4M;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/bk_clk_rst_gen_ce_div.sv
// Fixed-ratio wrap counter producing a registered one-cycle terminal-count enable.
module ce_div
    import bk_clk_pkg::*;
#(
    parameter int unsigned DIV = 12
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic clr,
    output logic ce
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ce_q, ce_d;

    // Next count and enable; enable decodes the count the next cycle will hold
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
        if (clr) begin
            cnt_d = '0;
        end
        ce_d = !clr && (cnt_d == LAST);
    end

    // Counter and enable registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ce_q  <= ce_d;
        end
    end

    assign ce = ce_q;

endmodule

// File: rtl/bk_clk_rst_gen.sv
// Lock-qualified core reset sequencer and clock-enable generator on clk_sys.
module bk_clk_rst_gen
    import bk_clk_pkg::*;
#(
    parameter int unsigned RST_HOLD = 1024,
    parameter int unsigned DIV_PIX  = 12,
    parameter int unsigned DIV_PSG  = 54
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic [1:0] speed,
    output logic       core_reset,
    output logic       ce_cpu,
    output logic       ce_cpu_n,
    output logic       ce_pix,
    output logic       ce_psg
);

    localparam int unsigned HW = $clog2(RST_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

    logic                 sync1_q, sync1_d;
    logic                 lk_q, lk_d;
    state_e               state_q, state_d;
    logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
    logic                 core_reset_q, core_reset_d;
    logic [DIV_W-1:0]     div_act_q, div_act_d;
    logic [CPU_CNT_W-1:0] cpu_cnt_q, cpu_cnt_d;
    logic                 ce_cpu_q, ce_cpu_d;
    logic                 ce_cpu_n_q, ce_cpu_n_d;
    logic                 clr_c;

    // Lock synchroniser, hold FSM and CPU divider next-state logic
    always_comb begin
        sync1_d    = pll_locked;
        lk_d       = sync1_q;
        state_d    = state_q;
        hold_cnt_d = '0;

        if (!lk_q) begin
            state_d = ST_HOLD;
        end else begin
            case (state_q)
                ST_HOLD:  state_d = ST_COUNT;
                ST_COUNT: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                end
                ST_RUN:   state_d = ST_RUN;
                default:  state_d = ST_HOLD;
            endcase
        end

        core_reset_d = (state_d != ST_RUN);

        // Dividers sit at 0 through the last reset cycle so cycle 0 of RUN starts at count 0
        clr_c = core_reset_q || core_reset_d;

        // Rate changes only at a period boundary or while the core is held
        div_act_d = div_act_q;
        if (core_reset_q || ce_cpu_q) begin
            div_act_d = speed_div(speed);
        end

        cpu_cnt_d = cpu_cnt_q + CPU_CNT_W'(1);
        if (cpu_cnt_q == CPU_CNT_W'(div_act_q - 6'd1)) begin
            cpu_cnt_d = '0;
        end
        if (clr_c) begin
            cpu_cnt_d = '0;
        end

        ce_cpu_d   = !clr_c && (cpu_cnt_d == CPU_CNT_W'(div_act_d - 6'd1));
        ce_cpu_n_d = !clr_c && (cpu_cnt_d == CPU_CNT_W'((div_act_d >> 1) - 6'd1));
    end

    // State registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            lk_q         <= 1'b0;
            state_q      <= ST_HOLD;
            hold_cnt_q   <= '0;
            core_reset_q <= 1'b1;
            div_act_q    <= DIV_4M;
            cpu_cnt_q    <= '0;
            ce_cpu_q     <= 1'b0;
            ce_cpu_n_q   <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            lk_q         <= lk_d;
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            core_reset_q <= core_reset_d;
            div_act_q    <= div_act_d;
            cpu_cnt_q    <= cpu_cnt_d;
            ce_cpu_q     <= ce_cpu_d;
            ce_cpu_n_q   <= ce_cpu_n_d;
        end
    end

    ce_div #(.DIV(DIV_PIX)) u_pix (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clr     (clr_c),
        .ce      (ce_pix)
    );

    ce_div #(.DIV(DIV_PSG)) u_psg (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clr     (clr_c),
        .ce      (ce_psg)
    );

    assign core_reset = core_reset_q;
    assign ce_cpu     = ce_cpu_q;
    assign ce_cpu_n   = ce_cpu_n_q;

endmodule
